fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction fetch stage. It owns the program counter and drives a synchronous-read instruction memory with one-cycle latency. Returned instructions and their PCs are buffered in a DEPTH-entry queue that feeds decode through a valid/ready handshake. A taken-branch redirect or a start pulse flushes the queue and discards any in-flight memory response.

## Interface
- AW, 9, PC / instruction address width
- IW, 9, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous; load PC from start_addr, flush, enter RUN
- start_addr  in  AW  start PC
- redirect  in  1  taken branch/jump from execute; ignored in IDLE
- redirect_target  in  AW  new PC
- imem_en  out  1  memory read request this cycle
- imem_addr  out  AW  read address (= PC register)
- imem_data  in  IW  read data, valid the cycle after imem_en
- out_valid  out  1  queue head valid
- out_instr  out  IW  queue head instruction
- out_pc  out  AW  queue head PC
- out_ready  in  1  decode accepts head
- fetch_count, flush_count  out  16 each  only with FETCH_PERF_EN

## Operation
- States: IDLE, RUN. Reset → IDLE, PC=0, queue empty, in-flight flag clear.
- Priority each cycle: start > redirect > normal fetch.
- start (any state): PC←start_addr, queue cleared, in-flight response dropped, state←RUN.
- redirect (RUN only): PC←redirect_target, queue cleared, in-flight response dropped.
- Issue: imem_en = RUN & !start & !redirect & credit. Credit = (occupancy − pop + inflight) < DEPTH, where pop = out_valid & out_ready this cycle. On issue, PC←PC+1 mod 2^AW (wraps 2^AW−1 → 0).
- Response: in the cycle after an issue (and not cancelled by start/redirect in the intervening edge), {imem_data, issued PC} is pushed at the tail.
- Pop: out_valid & out_ready removes the head. A pop in the same cycle as redirect/start completes (decode owns that instruction); all remaining entries are discarded.
- Simultaneous push and pop: occupancy unchanged. Overflow cannot occur (credit guarantees it); the bench asserts no push when full.
- out_valid = occupancy ≠ 0. out_instr/out_pc don't-care when out_valid=0, but 0 after reset.
- Reset mid-operation: all state returns immediately to reset values regardless of in-flight requests.

## Timing
- Reset values: imem_en=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0, counters=0.
- start asserted at cycle 0: imem_en=1 with imem_addr=start_addr at cycle 1, data at cycle 2, out_valid with out_pc=start_addr at cycle 3.
- redirect at cycle t: target requested at t+1, out_valid for target at t+3; no stale instruction ever appears after t.
- With out_ready held high, throughput is 1 instruction/cycle for any DEPTH ≥ 2.
- With out_ready low, issue stops once occupancy + inflight = DEPTH; resumes in the cycle out_ready returns.

## Configuration
- FETCH_PERF_EN defined: fetch_count increments per pushed instruction; flush_count increments per start or redirect that discards ≥1 queued or in-flight instruction. Both saturate at 0xFFFF and reset to 0.
- Undefined: both ports and counters are absent; no other behaviour changes.

## Test plan
- Reset, start with start_addr=0x010, out_ready=1 → out_valid first at cycle 3; out_pc sequence 0x010, 0x011, 0x012… one per cycle.
- out_ready=0 after start, DEPTH=4 → exactly 4 imem_en pulses, then imem_en=0. Raise out_ready → entries drain in order and fetching resumes.
- Steady stream at PC 0x020, redirect to 0x100 at cycle t → nothing with pc 0x021+ after t; next out_pc=0x100 at t+3. With FETCH_PERF_EN, flush_count=1.
- start_addr=0x1FE (AW=9) → out_pc 0x1FE, 0x1FF, 0x000, 0x001.
- redirect and start in the same cycle → PC follows start_addr. redirect in IDLE → no imem_en.
- rst_n low while queue is full and a response is in flight → all outputs 0 immediately. After release, no out_valid until start.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction-memory and decode-side bus of fetch_queue_unit
// master = the fetch unit, slave = memory plus decode.
interface fetch_queue_unit_if #(
    parameter int AW = 9,
    parameter int IW = 9
);
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc,
        input  imem_data, out_ready
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc,
        output imem_data, out_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC owner, 1-cycle imem requester and DEPTH-entry fetch queue
// Optional FETCH_PERF_EN adds saturating fetch_count / flush_count outputs.
module fetch_queue_unit #(
    parameter int AW    = 9,
    parameter int IW    = 9,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     start_addr,
    input  logic              redirect,
    input  logic [AW-1:0]     redirect_target,
`ifdef FETCH_PERF_EN
    output logic [15:0]       fetch_count,
    output logic [15:0]       flush_count,
`endif
    fetch_queue_unit_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   pc;
    logic            inflight;
    logic [AW-1:0]   inflight_pc;
    logic [IW-1:0]   q_instr [DEPTH];
    logic [AW-1:0]   q_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            pop, push, flush, issue, credit;
    logic [CW:0]     level;

    assign bus.out_valid = (count != '0);
    assign bus.out_instr = q_instr[rd_ptr];
    assign bus.out_pc    = q_pc[rd_ptr];
    assign pop           = bus.out_valid & bus.out_ready;

    // Slots already promised: entries that stay after this pop plus the response on its way.
    assign level  = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);
    assign credit = (level < DEPTH_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        flush      = 1'b0;
        issue      = 1'b0;
        if (start) begin
            state_next = RUN;
            flush      = 1'b1;
        end else if (state == RUN) begin
            if (redirect) begin
                flush = 1'b1;
            end else begin
                issue = credit;
            end
        end
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc;
    // A response landing in a flush cycle belongs to the old stream and is dropped.
    assign push          = inflight & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (flush) begin
                pc <= start ? start_addr : redirect_target;
            end else if (issue) begin
                pc          <= pc + AW'(1);
                inflight_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= bus.imem_data;
                q_pc[wr_ptr]    <= inflight_pc;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic discard;

    // A flush only counts when it actually throws work away.
    assign discard = inflight | ((count - CW'(pop)) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (flush && discard && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - randomized and directed bench for fetch_queue_unit
// Reference model: a queue of {instr, pc} plus one pending-read slot.
module tb_fetch_queue_unit;
    localparam int AW    = 9;
    localparam int IW    = 9;
    localparam int DEPTH = 4;

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          redirect;
    logic [AW-1:0] redirect_target;
`ifdef FETCH_PERF_EN
    logic [15:0]   fetch_count;
    logic [15:0]   flush_count;
`endif

    fetch_queue_unit_if #(.AW(AW), .IW(IW)) bus ();

    fetch_queue_unit #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_addr      (start_addr),
        .redirect        (redirect),
        .redirect_target (redirect_target),
`ifdef FETCH_PERF_EN
        .fetch_count     (fetch_count),
        .flush_count     (flush_count),
`endif
        .bus             (bus)
    );

    int checks = 0;
    int errors = 0;

    bit            m_run;
    logic [AW-1:0] m_pc;
    bit            m_pend;
    logic [AW-1:0] m_pend_addr;
    ent_t          m_q[$];
    int            m_fetch, m_flush;

    int            cyc;
    int            first_valid_cyc;
    int            en_pulses;
    bit            last_en;
    logic [AW-1:0] seen_pc[$];
    int            seen_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_func(input logic [AW-1:0] a);
        return IW'(a * 9'd37) ^ 9'h0A5;
    endfunction

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= mem_func(bus.imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pc = '0; m_pend = 0; m_pend_addr = '0;
        m_q.delete(); m_fetch = 0; m_flush = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},    bus.imem_en,   0);
        check({tag, "_addr"},  bus.imem_addr, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_instr"}, bus.out_instr, 0);
        check({tag, "_pc"},    bus.out_pc,    0);
`ifdef FETCH_PERF_EN
        check({tag, "_fcnt"},  fetch_count,   0);
        check({tag, "_flcnt"}, flush_count,   0);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0; start = 0; redirect = 0; start_addr = '0; redirect_target = '0;
        bus.out_ready = 0;
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cyc = 0;
        first_valid_cyc = -1;
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic step(input bit st, input logic [AW-1:0] sa, input bit rd,
                        input logic [AW-1:0] rt, input bit rdy);
        bit pop, flush, exp_en, discard;
        int occ;
        @(negedge clk);
        start = st; start_addr = sa; redirect = rd; redirect_target = rt;
        bus.out_ready = rdy;
        #1;
        pop    = (m_q.size() > 0) && rdy;
        flush  = st || (m_run && rd);
        occ    = m_q.size() - int'(pop) + int'(m_pend);
        exp_en = m_run && !st && !rd && (occ < DEPTH);

        check("imem_en",   bus.imem_en,   exp_en);
        check("imem_addr", bus.imem_addr, m_pc);
        check("out_valid", bus.out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("out_pc",    bus.out_pc,    m_q[0].pc);
            check("out_instr", bus.out_instr, m_q[0].instr);
        end
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, m_fetch);
        check("flush_count", flush_count, m_flush);
`endif
        check("push_when_full", dut.push && (dut.count == DEPTH), 0);

        last_en = bus.imem_en;
        if (bus.imem_en) en_pulses++;
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_valid && rdy) begin
            seen_pc.push_back(bus.out_pc);
            seen_cyc.push_back(cyc);
        end

        if (pop) void'(m_q.pop_front());
        if (flush) begin
            discard = (m_q.size() > 0) || m_pend;
            if (discard && m_flush < 16'hFFFF) m_flush++;
            m_q.delete();
            m_pend = 0;
            m_pc   = st ? sa : rt;
            if (st) m_run = 1;
        end else begin
            if (m_pend) begin
                m_q.push_back('{instr: mem_func(m_pend_addr), pc: m_pend_addr});
                if (m_fetch < 16'hFFFF) m_fetch++;
            end
            m_pend = exp_en;
            if (exp_en) begin
                m_pend_addr = m_pc;
                m_pc        = m_pc + 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic clear_seen();
        seen_pc.delete();
        seen_cyc.delete();
    endtask

    initial begin
        int t;
        rst_n = 0; start = 0; redirect = 0; start_addr = '0; redirect_target = '0;
        bus.out_ready = 0;
        model_reset();

        // Start latency and sequential stream
        apply_reset();
        clear_seen();
        step(1, 9'h010, 0, 0, 1);
        repeat (8) step(0, 0, 0, 0, 1);
        check("first_valid_cycle", first_valid_cyc, 3);
        check("seq0", seen_pc[0], 9'h010);
        check("seq1", seen_pc[1], 9'h011);
        check("seq2", seen_pc[2], 9'h012);
        check("seq_rate", seen_cyc[2] - seen_cyc[0], 2);

        // Back-pressure: exactly DEPTH reads, then resume on ready
        apply_reset();
        step(1, 9'h040, 0, 0, 0);
        en_pulses = 0;
        repeat (8) step(0, 0, 0, 0, 0);
        check("stall_pulses", en_pulses, DEPTH);
        check("stall_en_low", last_en, 0);
        clear_seen();
        step(0, 0, 0, 0, 1);
        check("resume_en", last_en, 1);
        repeat (7) step(0, 0, 0, 0, 1);
        check("drain0", seen_pc[0], 9'h040);
        check("drain3", seen_pc[3], 9'h043);
        check("drain4", seen_pc[4], 9'h044);

        // Redirect mid-stream
        apply_reset();
        step(1, 9'h020, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        t = cyc;
        step(0, 0, 1, 9'h100, 1);
        clear_seen();
        repeat (5) step(0, 0, 0, 0, 1);
        check("redir_pc", seen_pc[0], 9'h100);
        check("redir_cycle", seen_cyc[0], t + 3);
`ifdef FETCH_PERF_EN
        check("redir_flush_count", flush_count, 1);
`endif

        // PC wrap at 2^AW
        apply_reset();
        clear_seen();
        step(1, 9'h1FE, 0, 0, 1);
        repeat (7) step(0, 0, 0, 0, 1);
        check("wrap0", seen_pc[0], 9'h1FE);
        check("wrap1", seen_pc[1], 9'h1FF);
        check("wrap2", seen_pc[2], 9'h000);
        check("wrap3", seen_pc[3], 9'h001);

        // Redirect in IDLE, then start beats redirect
        apply_reset();
        en_pulses = 0;
        repeat (3) step(0, 0, 1, 9'h077, 1);
        check("idle_redirect_en", en_pulses, 0);
        clear_seen();
        step(1, 9'h0A0, 1, 9'h155, 1);
        repeat (5) step(0, 0, 0, 0, 1);
        check("start_wins", seen_pc[0], 9'h0A0);

        // Reset while busy with a read outstanding
        apply_reset();
        step(1, 9'h0C0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        en_pulses = 0;
        first_valid_cyc = -1;
        repeat (6) step(0, 0, $urandom_range(0, 1), 9'($urandom), 1);
        check("post_reset_idle_valid", first_valid_cyc, -1);
        check("post_reset_idle_en", en_pulses, 0);

        // Randomized traffic
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            bit st, rd, rdy;
            st  = ($urandom_range(0, 39) == 0) || (i == 0);
            rd  = ($urandom_range(0, 14) == 0);
            rdy = (i < 750) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            step(st, 9'($urandom), rd, 9'($urandom), rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
